bnn_layer_sched: RTL and testbench
==================================

BNN_LAYER_SCHED -- requirements
Module: bnn_layer_sched

Interface
REQ-001 SHALL have parameter N_BITS, default 256: dot-product length in bits.
REQ-002 SHALL have parameter WORD_W, default 32: word width.
REQ-003 SHALL have parameter N_WORDS, default N_BITS/WORD_W: words per dot product.
REQ-004 SHALL have parameter N_OUT, default 16: output neurons per layer.
REQ-005 SHALL have parameter TIMEOUT, default 64: maximum cycles from last_word to dot_done.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 cmd_start  in  1  single-cycle layer start request.
REQ-010 cmd_thr  in  32 signed  threshold, sampled on an accepted cmd_start.
REQ-011 busy  out  1  high from the accepted start until done.
REQ-012 done  out  1  one-cycle pulse at layer end.
REQ-013 err  out  1  sticky timeout flag, cleared by the next accepted cmd_start.
REQ-014 act_addr  out  clog2(N_WORDS)  activation word address; sync memory, 1-cycle read latency.
REQ-015 act_rdata  in  WORD_W  activation word.
REQ-016 wgt_addr  out  clog2(N_OUT*N_WORDS)  weight word address; 1-cycle read latency.
REQ-017 wgt_rdata  in  WORD_W  weight word.
REQ-018 dot_start, dot_word_valid, dot_last_word  out  1 each  dot-engine controls.
REQ-019 dot_a_word, dot_w_word  out  WORD_W  operands to the dot engine.
REQ-020 dot_done  in  1  dot engine result strobe.
REQ-021 dot_acc  in  32 signed  dot engine result.
REQ-022 out_valid/out_ready  out/in  1  result handshake.
REQ-023 out_idx  out  clog2(N_OUT)  neuron index of the result.
REQ-024 out_bit  out  1  binarized result.
REQ-025 out_vec  out  N_OUT  packed layer result.

Function
REQ-026 FSM states SHALL be IDLE, START, FETCH, DRAIN, WAIT, EMIT, FIN.
REQ-027 IDLE: cmd_start=1 -> START with neuron index n=0; thr latched; err cleared; out_vec cleared. cmd_start is ignored in every other state.
REQ-028 START: dot_start=1 for exactly one cycle -> FETCH with word counter k=0.
REQ-029 FETCH: each cycle, act_addr=k and wgt_addr=n*N_WORDS+k; k increments; after k=N_WORDS-1 -> DRAIN.
REQ-030 dot_word_valid SHALL be the FETCH-issue strobe delayed 1 cycle.
REQ-031 dot_a_word/dot_w_word SHALL equal act_rdata/wgt_rdata while dot_word_valid=1.
REQ-032 dot_last_word SHALL be asserted with the valid word for k=N_WORDS-1 only.
REQ-033 This gives exactly N_WORDS back-to-back valid words per neuron.
REQ-034 DRAIN: lasts one cycle while the last word is presented -> WAIT.
REQ-035 WAIT: on dot_done, capture out_bit=(dot_acc>=thr) -> EMIT.
REQ-036 WAIT: if TIMEOUT cycles elapse without dot_done, set err, drive out_bit=0 -> EMIT.
REQ-037 A dot_done outside WAIT SHALL be ignored.
REQ-038 EMIT: out_valid=1 with out_idx=n; out_bit, out_idx and out_vec are stable until out_ready.
REQ-039 EMIT, on the handshake cycle: out_vec[n]=out_bit; if n=N_OUT-1 -> FIN, else n+1 -> START.
REQ-040 FIN: done=1 for one cycle -> IDLE; busy falls in the same cycle.
REQ-041 out_ready=1 before out_valid SHALL have no effect.
REQ-042 Latency per neuron SHALL be 1 (START) + N_WORDS (FETCH) + 1 (DRAIN) + dot latency + 1 (EMIT, with out_ready held high).
REQ-043 Threshold compare SHALL be signed 32-bit; dot_acc=thr gives 1.

Reset
REQ-044 rst=1 at any time SHALL force IDLE, n=k=0, and zero on all outputs, including out_vec, err and addresses.
REQ-045 An in-flight layer SHALL be abandoned without a done pulse; operation resumes on the first clk edge after rst falls.

Structure
REQ-046 Shared package bnn_sched_pkg SHALL hold the FSM state encoding, default N_BITS/WORD_W and the 32-bit accumulator width constant.
REQ-047 One sub-module SHALL exist: bnn_word_fetch, which holds the k counter, address generation and the 1-cycle valid/last delay pipe.
REQ-048 The dot engine SHALL be instantiated outside this block.

Verification
REQ-049 All-ones act, all-ones wgt for neuron 0, thr=256, out_ready tied high: expect out_idx=0, out_bit=1, exactly 8 dot_word_valid pulses, last_word on the 8th.
REQ-050 thr=0, dot_acc model returns -2 for every neuron: expect out_vec=16'h0000, done pulse once, busy low the next cycle.
REQ-051 out_ready held low 10 cycles in EMIT: outputs stay stable and no new dot_start is issued.
REQ-052 Model withholds dot_done for neuron 3: expect err=1 after 64 cycles, out_vec[3]=0, remaining neurons complete, done asserted.
REQ-053 rst pulsed during FETCH of neuron 5: expect all outputs 0 and no done; a following cmd_start restarts at neuron 0 with wgt_addr=0.
REQ-054 cmd_start pulsed while busy: expect no effect, and layer count and timing unchanged.

Source files
------------

// File: rtl/bnn_sched_pkg.sv
// Shared definitions for the binary-neural-network layer scheduler:
// FSM encoding, default geometry and the accumulator width.
package bnn_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WAIT  = 3'd4,
    ST_EMIT  = 3'd5,
    ST_FIN   = 3'd6
  } sched_state_t;

  localparam int DEF_N_BITS = 256;
  localparam int DEF_WORD_W = 32;
  localparam int ACC_W      = 32;

  // Address width for a given depth; a single-entry space still needs one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bnn_word_fetch.sv
// Word fetch for one dot product: k counter, activation/weight address
// generation and the one-cycle valid/last pipe matching the memory latency.
module bnn_word_fetch
  import bnn_sched_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int N_WORDS = DEF_N_BITS / DEF_WORD_W,
  parameter int AA_W    = 3,
  parameter int WA_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              issue,
  input  logic [WA_W-1:0]   base,
  input  logic [WORD_W-1:0] act_rdata,
  input  logic [WORD_W-1:0] wgt_rdata,
  output logic [AA_W-1:0]   act_addr,
  output logic [WA_W-1:0]   wgt_addr,
  output logic              k_last,
  output logic              dot_word_valid,
  output logic              dot_last_word,
  output logic [WORD_W-1:0] dot_a_word,
  output logic [WORD_W-1:0] dot_w_word
);

  localparam logic [AA_W-1:0] K_LAST = AA_W'(N_WORDS - 1);

  logic [AA_W-1:0] k_r;
  logic [WA_W-1:0] wgt_addr_r;
  logic            valid_r;
  logic            last_r;
  logic            k_last_s;

  assign k_last_s = issue && (k_r == K_LAST);

  // Address counters plus the issue-to-data alignment pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r        <= '0;
      wgt_addr_r <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      valid_r <= issue;
      last_r  <= k_last_s;
      if (load) begin
        k_r        <= '0;
        wgt_addr_r <= base;
      end else if (issue) begin
        if (k_last_s) begin
          k_r        <= '0;
          wgt_addr_r <= wgt_addr_r;
        end else begin
          k_r        <= k_r + AA_W'(1);
          wgt_addr_r <= wgt_addr_r + WA_W'(1);
        end
      end else begin
        k_r        <= k_r;
        wgt_addr_r <= wgt_addr_r;
      end
    end
  end

  assign act_addr       = k_r;
  assign wgt_addr       = wgt_addr_r;
  assign k_last         = k_last_s;
  assign dot_word_valid = valid_r;
  assign dot_last_word  = last_r;
  // Read data arrives one cycle after issue, exactly when valid_r is high.
  assign dot_a_word     = valid_r ? act_rdata : '0;
  assign dot_w_word     = valid_r ? wgt_rdata : '0;

endmodule

// File: rtl/bnn_layer_sched.sv
// Layer scheduler: sequences N_OUT dot products through an external engine,
// binarizes each result against a threshold and hands them out one by one.
module bnn_layer_sched
  import bnn_sched_pkg::*;
#(
  parameter int N_BITS  = DEF_N_BITS,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int N_WORDS = N_BITS / WORD_W,
  parameter int N_OUT   = 16,
  parameter int TIMEOUT = 64,
  localparam int AA_W   = addr_w(N_WORDS),
  localparam int WA_W   = addr_w(N_OUT * N_WORDS),
  localparam int IDX_W  = addr_w(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_start,
  input  logic signed [ACC_W-1:0] cmd_thr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [AA_W-1:0]         act_addr,
  input  logic [WORD_W-1:0]       act_rdata,
  output logic [WA_W-1:0]         wgt_addr,
  input  logic [WORD_W-1:0]       wgt_rdata,
  output logic                    dot_start,
  output logic                    dot_word_valid,
  output logic                    dot_last_word,
  output logic [WORD_W-1:0]       dot_a_word,
  output logic [WORD_W-1:0]       dot_w_word,
  input  logic                    dot_done,
  input  logic signed [ACC_W-1:0] dot_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_bit,
  output logic [N_OUT-1:0]        out_vec
);

  localparam int TMO_W = addr_w(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] N_LAST   = IDX_W'(N_OUT - 1);

  sched_state_t             state_r, state_nx_s;
  logic [IDX_W-1:0]         n_r, n_nx_s;
  logic signed [ACC_W-1:0]  thr_r, thr_nx_s;
  logic                     err_r, err_nx_s;
  logic                     bit_r, bit_nx_s;
  logic [N_OUT-1:0]         vec_r, vec_nx_s;
  logic [TMO_W-1:0]         tmo_r, tmo_nx_s;
  logic                     busy_r, done_r, dot_start_r, out_valid_r;
  logic                     k_last_s;
  logic [WA_W-1:0]          wgt_base_s;

  assign wgt_base_s = WA_W'(n_r) * WA_W'(N_WORDS);

  bnn_word_fetch #(
    .WORD_W (WORD_W),
    .N_WORDS(N_WORDS),
    .AA_W   (AA_W),
    .WA_W   (WA_W)
  ) u_fetch (
    .clk           (clk),
    .rst           (rst),
    .load          (state_r == ST_START),
    .issue         (state_r == ST_FETCH),
    .base          (wgt_base_s),
    .act_rdata     (act_rdata),
    .wgt_rdata     (wgt_rdata),
    .act_addr      (act_addr),
    .wgt_addr      (wgt_addr),
    .k_last        (k_last_s),
    .dot_word_valid(dot_word_valid),
    .dot_last_word (dot_last_word),
    .dot_a_word    (dot_a_word),
    .dot_w_word    (dot_w_word)
  );

  // Next-state and next-data decode for the layer sequence.
  always_comb begin
    state_nx_s = state_r;
    n_nx_s     = n_r;
    thr_nx_s   = thr_r;
    err_nx_s   = err_r;
    bit_nx_s   = bit_r;
    vec_nx_s   = vec_r;
    tmo_nx_s   = tmo_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_start) begin
          state_nx_s = ST_START;
          n_nx_s     = '0;
          thr_nx_s   = cmd_thr;
          err_nx_s   = 1'b0;
          bit_nx_s   = 1'b0;
          vec_nx_s   = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: state_nx_s = ST_FETCH;
      ST_FETCH: begin
        if (k_last_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        state_nx_s = ST_WAIT;
        tmo_nx_s   = '0;
      end
      ST_WAIT: begin
        if (dot_done) begin
          bit_nx_s   = (dot_acc >= thr_r);
          state_nx_s = ST_EMIT;
        end else if (tmo_r == TMO_LAST) begin
          err_nx_s   = 1'b1;
          bit_nx_s   = 1'b0;
          state_nx_s = ST_EMIT;
        end else begin
          tmo_nx_s   = tmo_r + TMO_W'(1);
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          vec_nx_s[n_r] = bit_r;
          if (n_r == N_LAST) begin
            state_nx_s = ST_FIN;
          end else begin
            n_nx_s     = n_r + IDX_W'(1);
            state_nx_s = ST_START;
          end
        end else begin
          state_nx_s = ST_EMIT;
        end
      end
      ST_FIN:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, datapath registers and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      n_r         <= '0;
      thr_r       <= '0;
      err_r       <= 1'b0;
      bit_r       <= 1'b0;
      vec_r       <= '0;
      tmo_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dot_start_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      n_r         <= n_nx_s;
      thr_r       <= thr_nx_s;
      err_r       <= err_nx_s;
      bit_r       <= bit_nx_s;
      vec_r       <= vec_nx_s;
      tmo_r       <= tmo_nx_s;
      busy_r      <= state_nx_s inside {ST_START, ST_FETCH, ST_DRAIN, ST_WAIT, ST_EMIT};
      done_r      <= (state_nx_s == ST_FIN);
      dot_start_r <= (state_nx_s == ST_START);
      out_valid_r <= (state_nx_s == ST_EMIT);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign dot_start = dot_start_r;
  assign out_valid = out_valid_r;
  assign out_idx   = n_r;
  assign out_bit   = bit_r;
  assign out_vec   = vec_r;

endmodule

// File: tb/tb_bnn_layer_sched.sv
// Directed self-checking bench for bnn_layer_sched with behavioural
// activation/weight memories and an XNOR-popcount dot engine model.
module tb_bnn_layer_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               cmd_start = 1'b0;
  logic signed [31:0] cmd_thr   = 32'sd0;
  logic               out_ready = 1'b1;
  logic               busy, done, err, dot_start, dot_word_valid, dot_last_word;
  logic               out_valid, out_bit;
  logic [2:0]         act_addr;
  logic [6:0]         wgt_addr;
  logic [3:0]         out_idx;
  logic [15:0]        out_vec;
  logic [31:0]        dot_a_word, dot_w_word;
  logic [31:0]        act_rdata, wgt_rdata;
  logic [31:0]        act_mem [8];
  logic [31:0]        wgt_mem [128];

  // Dot-engine model state and stimulus overrides
  logic               m_done    = 1'b0;
  logic signed [31:0] m_acc     = 32'sd0;
  int                 m_run     = 0;
  int                 ds_cnt    = 0;
  int                 cur_n     = 0;
  int                 vcnt      = 0;
  int                 last_at   = 0;
  logic               force_en  = 1'b0;
  logic signed [31:0] force_val = 32'sd0;
  logic               inj_done  = 1'b0;
  logic               hold_en   = 1'b0;
  int                 hold_tgt  = 0;
  logic               dot_done_s;
  logic signed [31:0] dot_acc_s;

  assign dot_done_s = m_done | inj_done;
  assign dot_acc_s  = force_en ? force_val : m_acc;

  bnn_layer_sched dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_thr(cmd_thr),
    .busy(busy), .done(done), .err(err),
    .act_addr(act_addr), .act_rdata(act_rdata),
    .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
    .dot_start(dot_start), .dot_word_valid(dot_word_valid), .dot_last_word(dot_last_word),
    .dot_a_word(dot_a_word), .dot_w_word(dot_w_word),
    .dot_done(dot_done_s), .dot_acc(dot_acc_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_bit(out_bit), .out_vec(out_vec)
  );

  // Synchronous memories with one cycle of read latency
  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    wgt_rdata <= wgt_mem[wgt_addr];
  end

  function automatic int word_score(input logic [31:0] a, input logic [31:0] w);
    return 2 * $countones(~(a ^ w)) - 32;
  endfunction

  // Dot engine: accumulates valid words, strobes dot_done one cycle after the last word
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (dot_start) begin
      m_run  <= 0;
      cur_n  <= ds_cnt;
      ds_cnt <= ds_cnt + 1;
      vcnt   <= 0;
    end else if (dot_word_valid) begin
      m_run <= m_run + word_score(dot_a_word, dot_w_word);
      vcnt  <= vcnt + 1;
      if (dot_last_word) begin
        last_at <= vcnt + 1;
        if (!(hold_en && cur_n == hold_tgt)) begin
          m_done <= 1'b1;
          m_acc  <= m_run + word_score(dot_a_word, dot_w_word);
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wgt(input logic [15:0] mask);
    for (int n = 0; n < 16; n++)
      for (int k = 0; k < 8; k++)
        wgt_mem[n*8+k] = mask[n] ? 32'hFFFF_FFFF : 32'h0000_0000;
  endtask

  logic [31:0] rec_vec0, rec_err0, rec_busy0, rec_wa1, rec_wa2, rec_idx1;
  logic [31:0] rec_err2, rec_err3, rec_bit3, rec_v0, rec_l0, rec_bit0, rec_lat0, rec_busy_after;

  task automatic run_layer(input logic [31:0] thr, input bit poke, output int cyc, output int ndone);
    bit got0;
    got0 = 1'b0;
    cmd_thr = thr;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    rec_vec0 = 32'(out_vec); rec_err0 = 32'(err); rec_busy0 = 32'(busy);
    cyc = 0; ndone = 0;
    while (cyc < 1000 && ndone == 0) begin
      if (poke) cmd_start = (cyc == 5 || cyc == 100 || cyc == 150);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin rec_wa1 = 32'(wgt_addr); rec_idx1 = 32'(out_idx); end
      if (cyc == 2) rec_wa2 = 32'(wgt_addr);
      if (out_valid && out_idx == 4'd2) rec_err2 = 32'(err);
      if (out_valid && out_idx == 4'd3) begin rec_err3 = 32'(err); rec_bit3 = 32'(out_bit); end
      if (out_valid && out_idx == 4'd0 && !got0) begin
        got0 = 1'b1;
        rec_v0 = 32'(vcnt); rec_l0 = 32'(last_at); rec_bit0 = 32'(out_bit); rec_lat0 = 32'(cyc);
      end
      if (done) ndone++;
    end
    cmd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) rec_busy_after = 32'(busy);
      if (done) ndone++;
    end
  endtask

  int cyc, nd, w, ds0, stable;
  logic [31:0] s_idx, s_bit, s_vec;

  initial begin
    for (int i = 0; i < 8; i++) act_mem[i] = 32'hFFFF_FFFF;
    set_wgt(16'h0001);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_ctl", {10'd0, busy, done, err, out_valid, out_bit, dot_start, dot_word_valid,
                         dot_last_word, out_idx, act_addr, wgt_addr}, 32'd0);
    chk_eq("reset_vec", 32'(out_vec), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Neuron 0 all ones against thr=256, others -256
    run_layer(32'd256, 1'b0, cyc, nd);
    chk_eq("t1_idx1", rec_idx1, 32'd0);
    chk_eq("t1_valid_words", rec_v0, 32'd8);
    chk_eq("t1_last_on_8th", rec_l0, 32'd8);
    chk_eq("t1_bit0", rec_bit0, 32'd1);
    chk_eq("t1_neuron_latency", rec_lat0, 32'd11);
    chk_eq("t1_vec", 32'(out_vec), 32'h0001);
    chk_eq("t1_layer_cycles", 32'(cyc), 32'd192);
    chk_eq("t1_done_count", 32'(nd), 32'd1);

    // Forced dot_acc=-2 against thr=0 gives all zeros
    set_wgt(16'hFFFF);
    force_val = -32'sd2; force_en = 1'b1;
    run_layer(32'd0, 1'b0, cyc, nd);
    force_en = 1'b0;
    chk_eq("t2_vec_cleared_on_start", rec_vec0, 32'd0);
    chk_eq("t2_busy_during", rec_busy0, 32'd1);
    chk_eq("t2_vec", 32'(out_vec), 32'h0000);
    chk_eq("t2_done_count", 32'(nd), 32'd1);
    chk_eq("t2_busy_after_done", rec_busy_after, 32'd0);

    // Back-pressure on neuron 0 plus a stray dot_done during EMIT
    set_wgt(16'h0001);
    out_ready = 1'b0;
    cmd_thr = 32'sd256; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    chk_eq("t3_reach_emit", 32'(out_valid), 32'd1);
    s_idx = 32'(out_idx); s_bit = 32'(out_bit); s_vec = 32'(out_vec); ds0 = ds_cnt; stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin force_val = -32'sd5; force_en = 1'b1; inj_done = 1'b1; end
      @(posedge clk); #1;
      inj_done = 1'b0; force_en = 1'b0;
      if (!out_valid || 32'(out_idx) != s_idx || 32'(out_bit) != s_bit || 32'(out_vec) != s_vec) stable = 0;
    end
    chk_eq("t3_stable", 32'(stable), 32'd1);
    chk_eq("t3_idx", s_idx, 32'd0);
    chk_eq("t3_bit", s_bit, 32'd1);
    chk_eq("t3_vec_before_hs", s_vec, 32'd0);
    chk_eq("t3_no_new_start", 32'(ds_cnt), 32'(ds0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_eq("t3_vec_after_hs", 32'(out_vec), 32'h0001);
    chk_eq("t3_valid_after_hs", 32'(out_valid), 32'd0);
    w = 0;
    while (!done && w < 400) begin @(posedge clk); #1; w++; end
    chk_eq("t3_done", 32'(done), 32'd1);
    chk_eq("t3_final_vec", 32'(out_vec), 32'h0001);
    @(posedge clk); #1;

    // Neuron 3 never finishes: timeout, err, bit forced to 0
    set_wgt(16'h555D);
    hold_tgt = ds_cnt + 3; hold_en = 1'b1;
    run_layer(32'd0, 1'b0, cyc, nd);
    hold_en = 1'b0;
    chk_eq("t4_err_before", rec_err2, 32'd0);
    chk_eq("t4_err_at3", rec_err3, 32'd1);
    chk_eq("t4_bit3", rec_bit3, 32'd0);
    chk_eq("t4_vec", 32'(out_vec), 32'h5555);
    chk_eq("t4_layer_cycles", 32'(cyc), 32'd255);
    chk_eq("t4_done_count", 32'(nd), 32'd1);
    chk_eq("t4_err_sticky", 32'(err), 32'd1);

    // cmd_start pulses while busy are ignored
    run_layer(32'd0, 1'b1, cyc, nd);
    chk_eq("t6_err_cleared", rec_err0, 32'd0);
    chk_eq("t6_vec", 32'(out_vec), 32'h555D);
    chk_eq("t6_layer_cycles", 32'(cyc), 32'd192);
    chk_eq("t6_done_count", 32'(nd), 32'd1);

    // Reset in the middle of neuron 5 FETCH
    set_wgt(16'hFFFF);
    cmd_thr = 32'sd0; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    w = 0;
    while (!(dot_start && out_idx == 4'd5) && w < 200) begin @(posedge clk); #1; w++; end
    chk_eq("t5_reach_n5", 32'(out_idx), 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_eq("t5_in_fetch", 32'(dot_word_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_eq("t5_rst_ctl", {10'd0, busy, done, err, out_valid, out_bit, dot_start, dot_word_valid,
                          dot_last_word, out_idx, act_addr, wgt_addr}, 32'd0);
    chk_eq("t5_rst_vec", 32'(out_vec), 32'd0);
    chk_eq("t5_rst_words", dot_a_word | dot_w_word, 32'd0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) nd++; end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (done || busy) nd++; end
    chk_eq("t5_no_done", 32'(nd), 32'd0);
    run_layer(32'd0, 1'b0, cyc, nd);
    chk_eq("t5_restart_idx", rec_idx1, 32'd0);
    chk_eq("t5_restart_wa0", rec_wa1, 32'd0);
    chk_eq("t5_restart_wa1", rec_wa2, 32'd1);
    chk_eq("t5_vec", 32'(out_vec), 32'hFFFF);
    chk_eq("t5_layer_cycles", 32'(cyc), 32'd192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
